// File: rtl/cpu_run_ctrl.sv
// Run controller for a test core: holds it in reset, times the run, and latches
// the tohost mailbox result. Define RUN_CTRL_INSTRET_EN to add a retired-instruction counter.
module cpu_run_ctrl #(
    parameter int          RST_CYCLES  = 4,
    parameter int          MAX_CYCLES  = 100000,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
`ifdef RUN_CTRL_INSTRET_EN
    input  logic             instr_retire,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic             cpu_rst,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      fail_code
);

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

    // The cycle that ends a run is itself counted, so decisions use the incremented value.
    assign cnt_nxt = cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign hit     = mem_we && (mem_addr == TOHOST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            cpu_rst   <= 1'b1;
            cycle_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
`ifdef RUN_CTRL_INSTRET_EN
            instret_cnt <= '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                        cpu_rst  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RUN: begin
                    cycle_cnt <= cnt_nxt;
`ifdef RUN_CTRL_INSTRET_EN
                    if (instr_retire) instret_cnt <= instret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                    // A mailbox hit outranks a timeout landing on the same cycle.
                    if (hit) begin
                        state     <= DONE;
                        cpu_rst   <= 1'b1;
                        done      <= 1'b1;
                        pass      <= (mem_wdata == 32'd1);
                        fail_code <= mem_wdata[31:1];
                    end else if (cnt_nxt == TMO_LAST) begin
                        state   <= DONE;
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                DONE: ;
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized and directed bench for cpu_run_ctrl against a run-outcome model.
module tb_cpu_run_ctrl;

    localparam int          RST_C = 4;
    localparam int          MAX_C = 20;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, restart, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        cpu_rst, done, pass, timeout;
    logic [31:0] cycle_cnt;
    logic [30:0] fail_code;
`ifdef RUN_CTRL_INSTRET_EN
    logic        instr_retire;
    logic [31:0] instret_cnt;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(RST_C), .MAX_CYCLES(MAX_C), .CNT_W(32), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .rst(rst), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef RUN_CTRL_INSTRET_EN
        .instr_retire(instr_retire), .instret_cnt(instret_cnt),
`endif
        .cpu_rst(cpu_rst), .cycle_cnt(cycle_cnt), .done(done), .pass(pass),
        .timeout(timeout), .fail_code(fail_code)
    );

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rs, input logic ret);
        @(negedge clk);
        mem_we = we; mem_addr = a; mem_wdata = d; restart = rs;
`ifdef RUN_CTRL_INSTRET_EN
        instr_retire = ret;
`else
        if (ret) begin end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Number of edges until the core leaves reset; -1 if it never does.
    task automatic wait_run(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (!cpu_rst) begin n = i; break; end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0;
        idle(2);
        checks++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); else passed++;
        checks++; if ({done, pass, timeout} !== 3'b000) $display("FAIL reset_flags got %b want 000", {done, pass, timeout}); else passed++;
        checks++; if (fail_code !== 31'd0) $display("FAIL reset_fail_code got %0d want 0", fail_code); else passed++;
        checks++; if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); else passed++;
        rst = 1'b1;
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL reset_hold_len got %0d want %0d", n, RST_C); else passed++;
        checks++; if (cycle_cnt !== 32'd0) $display("FAIL run_start_cnt got %0d want 0", cycle_cnt); else passed++;
    endtask

    task automatic test_pass;
        int n;
        idle(9);
        checks++; if (cycle_cnt !== 32'd9 || done !== 1'b0) $display("FAIL pass_pre got cnt %0d done %b want 9 0", cycle_cnt, done); else passed++;
        cyc(1'b1, TOHOST, 32'd1, 1'b0, 1'b0);
        checks++; if ({done, pass, timeout} !== 3'b110) $display("FAIL pass_flags got %b want 110", {done, pass, timeout}); else passed++;
        checks++; if (cycle_cnt !== 32'd10) $display("FAIL pass_cnt got %0d want 10", cycle_cnt); else passed++;
        checks++; if (cpu_rst !== 1'b1 || fail_code !== 31'd0) $display("FAIL pass_rst_code got %b %0d want 1 0", cpu_rst, fail_code); else passed++;
        cyc(1'b1, TOHOST, 32'd5, 1'b0, 1'b0);
        idle(2);
        checks++; if ({done, pass, timeout} !== 3'b110 || fail_code !== 31'd0 || cycle_cnt !== 32'd10)
            $display("FAIL done_hold got %b code %0d cnt %0d want 110 0 10", {done, pass, timeout}, fail_code, cycle_cnt); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if ({done, pass, timeout} !== 3'b000 || cycle_cnt !== 32'd0 || cpu_rst !== 1'b1)
            $display("FAIL restart_done got %b cnt %0d rst %b want 000 0 1", {done, pass, timeout}, cycle_cnt, cpu_rst); else passed++;
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL restart_done_hold got %0d want %0d", n, RST_C); else passed++;
    endtask

    task automatic test_fail;
        int n;
        cyc(1'b1, TOHOST + 32'd4, 32'd1, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) $display("FAIL decoy_ignored got %b want 0", done); else passed++;
        idle(3);
        cyc(1'b1, TOHOST, 32'h0000_0007, 1'b0, 1'b0);
        checks++; if ({done, pass, timeout} !== 3'b100) $display("FAIL fail_flags got %b want 100", {done, pass, timeout}); else passed++;
        checks++; if (fail_code !== 31'd3 || cycle_cnt !== 32'd5) $display("FAIL fail_code got %0d cnt %0d want 3 5", fail_code, cycle_cnt); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL fail_rehold got %0d want %0d", n, RST_C); else passed++;
    endtask

    task automatic test_timeout;
        int n;
        idle(MAX_C - 2);
        checks++; if (done !== 1'b0 || cycle_cnt !== 32'(MAX_C - 2)) $display("FAIL tmo_pre got %b %0d want 0 %0d", done, cycle_cnt, MAX_C - 2); else passed++;
        idle(1);
        checks++; if ({done, pass, timeout} !== 3'b101 || cycle_cnt !== 32'(MAX_C - 1) || fail_code !== 31'd0)
            $display("FAIL tmo got %b cnt %0d code %0d want 101 %0d 0", {done, pass, timeout}, cycle_cnt, fail_code, MAX_C - 1); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_run(n);
        idle(MAX_C - 2);
        cyc(1'b1, TOHOST, 32'd1, 1'b0, 1'b0);
        checks++; if ({done, pass, timeout} !== 3'b110 || cycle_cnt !== 32'(MAX_C - 1))
            $display("FAIL hit_vs_tmo got %b cnt %0d want 110 %0d", {done, pass, timeout}, cycle_cnt, MAX_C - 1); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL tmo_rehold got %0d want %0d", n, RST_C); else passed++;
    endtask

    task automatic test_restart;
        int n;
        idle(5);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (cpu_rst !== 1'b1 || cycle_cnt !== 32'd0 || done !== 1'b0) $display("FAIL restart_mid got %b %0d %b want 1 0 0", cpu_rst, cycle_cnt, done); else passed++;
        idle(2);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL restart_in_hold got %0d want %0d", n, RST_C); else passed++;
        idle(3);
        cyc(1'b1, TOHOST, 32'd1, 1'b1, 1'b0);
        checks++; if (done !== 1'b0 || pass !== 1'b0 || cpu_rst !== 1'b1 || cycle_cnt !== 32'd0)
            $display("FAIL restart_vs_hit got done %b pass %b rst %b cnt %0d want 0 0 1 0", done, pass, cpu_rst, cycle_cnt); else passed++;
        wait_run(n);
        idle(MAX_C - 2);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (done !== 1'b0 || timeout !== 1'b0) $display("FAIL restart_vs_tmo got %b %b want 0 0", done, timeout); else passed++;
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL restart_vs_tmo_hold got %0d want %0d", n, RST_C); else passed++;
    endtask

    task automatic test_midrun_reset;
        int n;
        idle(6);
        @(negedge clk); rst = 1'b0; restart = 1'b1;
        @(posedge clk); #1;
        checks++; if (cpu_rst !== 1'b1 || cycle_cnt !== 32'd0 || done !== 1'b0) $display("FAIL midrun_reset got %b %0d %b want 1 0 0", cpu_rst, cycle_cnt, done); else passed++;
        rst = 1'b1; restart = 1'b0;
        wait_run(n);
        checks++; if (n !== RST_C) $display("FAIL midrun_reset_hold got %0d want %0d", n, RST_C); else passed++;
    endtask

`ifdef RUN_CTRL_INSTRET_EN
    task automatic test_instret;
        int n;
        logic [11:0] pat;
        pat = 12'b1011_0110_0101;
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, pat[i]);
        cyc(1'b1, TOHOST, 32'd1, 1'b0, 1'b0);
        checks++; if (instret_cnt !== 32'd7 || pass !== 1'b1) $display("FAIL instret got %0d pass %b want 7 1", instret_cnt, pass); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++; if (instret_cnt !== 32'd7) $display("FAIL instret_hold got %0d want 7", instret_cnt); else passed++;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (instret_cnt !== 32'd0) $display("FAIL instret_clear got %0d want 0", instret_cnt); else passed++;
        wait_run(n);
    endtask
`endif

    // Model: the run ends on the first mailbox hit, or at cycle MAX_C-1 if none came first.
    task automatic test_random;
        int n, hit_at, end_at, ret_cnt;
        logic [31:0] data, a;
        logic we, ret;
        for (int it = 0; it < 20; it++) begin
            hit_at  = $urandom_range(1, MAX_C + 4);
            data    = ($urandom_range(0, 2) == 0) ? 32'd1 : (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end_at  = (hit_at <= MAX_C - 1) ? hit_at : MAX_C - 1;
            ret_cnt = 0;
            for (int c = 1; c <= end_at; c++) begin
                ret = 1'($urandom_range(0, 1));
                if (c == hit_at) begin
                    we = 1'b1; a = TOHOST;
                end else if ($urandom_range(0, 1) == 0) begin
                    we = 1'b1; a = TOHOST + 32'(4 * $urandom_range(1, 8));
                end else begin
                    we = 1'b0; a = TOHOST;
                end
                cyc(we, a, (c == hit_at) ? data : $urandom, 1'b0, ret);
                if (ret) ret_cnt++;
                if (c < end_at) begin
                    checks++; if (done !== 1'b0 || cycle_cnt !== 32'(c)) $display("FAIL rnd_run it %0d c %0d got done %b cnt %0d want 0 %0d", it, c, done, cycle_cnt, c); else passed++;
                end
            end
            checks++;
            if (hit_at <= MAX_C - 1) begin
                if (done !== 1'b1 || pass !== (data == 32'd1) || timeout !== 1'b0 || fail_code !== data[31:1] || cycle_cnt !== 32'(end_at))
                    $display("FAIL rnd_hit it %0d got %b%b%b code %0h cnt %0d want data %0h cnt %0d", it, done, pass, timeout, fail_code, cycle_cnt, data, end_at);
                else passed++;
            end else begin
                if ({done, pass, timeout} !== 3'b101 || fail_code !== 31'd0 || cycle_cnt !== 32'(end_at))
                    $display("FAIL rnd_tmo it %0d got %b code %0h cnt %0d want 101 0 %0d", it, {done, pass, timeout}, fail_code, cycle_cnt, end_at);
                else passed++;
            end
`ifdef RUN_CTRL_INSTRET_EN
            checks++; if (instret_cnt !== 32'(ret_cnt)) $display("FAIL rnd_instret it %0d got %0d want %0d", it, instret_cnt, ret_cnt); else passed++;
`endif
            cyc(1'b1, TOHOST, 32'd1, 1'b0, 1'b1);
            checks++; if (done !== 1'b1 || cpu_rst !== 1'b1 || cycle_cnt !== 32'(end_at)) $display("FAIL rnd_frozen it %0d got %b %b %0d", it, done, cpu_rst, cycle_cnt); else passed++;
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            wait_run(n);
            checks++; if (n !== RST_C) $display("FAIL rnd_hold it %0d got %0d want %0d", it, n, RST_C); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
`ifdef RUN_CTRL_INSTRET_EN
        instr_retire = 1'b0;
`endif
        test_reset;
        test_pass;
        test_fail;
        test_timeout;
        test_restart;
        test_midrun_reset;
`ifdef RUN_CTRL_INSTRET_EN
        test_instret;
`endif
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
